// File: rtl/axil_sram_dma_master.sv
// ============================================================================
// Module      : axil_sram_dma_master
// Description : Command-driven AXI4-Lite master moving cmd_len 32-bit words
//               between a write/read stream pair and an SRAM AXI4-Lite slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_sram_dma_master #(
    parameter int LEN_W = 10
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             done,
    output logic             err,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_axi_awaddr,
    output logic             m_axi_awvalid,
    input  logic             m_axi_awready,
    output logic [31:0]      m_axi_wdata,
    output logic [3:0]       m_axi_wstrb,
    output logic             m_axi_wvalid,
    input  logic             m_axi_wready,
    input  logic [1:0]       m_axi_bresp,
    input  logic             m_axi_bvalid,
    output logic             m_axi_bready,
    output logic [31:0]      m_axi_araddr,
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    input  logic [31:0]      m_axi_rdata,
    input  logic [1:0]       m_axi_rresp,
    input  logic             m_axi_rvalid,
    output logic             m_axi_rready
);

    localparam logic [3:0] c_WSTRB_ALL = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_WADDR = 3'd2,
        S_WRESP = 3'd3,
        S_RADDR = 3'd4,
        S_RDATA = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_cnt;
    logic             r_err;
    logic [31:0]      r_wdata;
    logic             r_awvalid;
    logic             r_wvalid;
    logic             r_ar_hold;
    logic [31:0]      r_mdata;
    logic             r_mvalid;
    logic             r_cmd_ready;

    logic             w_m_free;
    logic             w_arvalid;
    logic             w_rready;
    logic             w_cmd_fire;
    logic             w_s_fire;
    logic             w_b_fire;
    logic             w_r_fire;
    logic             w_last;
    logic             w_aw_ok;
    logic             w_w_ok;

    always_comb begin
        w_next     = r_state;
        w_m_free   = !r_mvalid || m_ready;
        // Once an AR is presented it must stay up until accepted, even if
        // the output stream stalls in the meantime.
        w_arvalid  = (r_state == S_RADDR) && (r_ar_hold || w_m_free);
        w_rready   = (r_state == S_RDATA) && w_m_free;
        w_cmd_fire = cmd_valid && r_cmd_ready;
        w_s_fire   = (r_state == S_WLOAD) && s_valid;
        w_b_fire   = (r_state == S_WRESP) && m_axi_bvalid;
        w_r_fire   = w_rready && m_axi_rvalid;
        w_last     = (r_cnt == LEN_W'(1));
        w_aw_ok    = !r_awvalid || m_axi_awready;
        w_w_ok     = !r_wvalid || m_axi_wready;

        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    if (cmd_len == '0)  w_next = S_DONE;
                    else if (cmd_write) w_next = S_WLOAD;
                    else                w_next = S_RADDR;
                end
            end
            S_WLOAD: if (w_s_fire) w_next = S_WADDR;
            S_WADDR: if (w_aw_ok && w_w_ok) w_next = S_WRESP;
            S_WRESP: if (w_b_fire) w_next = w_last ? S_DONE : S_WLOAD;
            S_RADDR: if (w_arvalid && m_axi_arready) w_next = S_RDATA;
            S_RDATA: if (w_r_fire) w_next = w_last ? S_DONE : S_RADDR;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_wdata     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_ar_hold   <= 1'b0;
            r_mdata     <= '0;
            r_mvalid    <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == S_IDLE);
            r_ar_hold   <= w_arvalid && !m_axi_arready;

            if (w_cmd_fire) begin
                r_addr <= {cmd_addr[31:2], 2'b00};
                r_cnt  <= cmd_len;
                r_err  <= 1'b0;
            end

            if (w_s_fire) begin
                r_wdata   <= s_data;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
            end
            if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
            if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;

            if (w_b_fire) begin
                r_err  <= r_err | (m_axi_bresp != 2'b00);
                r_addr <= r_addr + 32'd4;
                r_cnt  <= r_cnt - LEN_W'(1);
            end

            if (w_r_fire) begin
                r_mdata  <= m_axi_rdata;
                r_mvalid <= 1'b1;
                r_err    <= r_err | (m_axi_rresp != 2'b00);
                r_addr   <= r_addr + 32'd4;
                r_cnt    <= r_cnt - LEN_W'(1);
            end else if (m_ready) begin
                r_mvalid <= 1'b0;
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign done          = (r_state == S_DONE);
    assign err           = r_err;
    assign s_ready       = (r_state == S_WLOAD);
    assign m_data        = r_mdata;
    assign m_valid       = r_mvalid;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wvalid ? c_WSTRB_ALL : 4'h0;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = (r_state == S_WRESP);
    assign m_axi_araddr  = r_addr;
    assign m_axi_arvalid = w_arvalid;
    assign m_axi_rready  = w_rready;

endmodule

`default_nettype wire

// File: tb/tb_axil_sram_dma_master.sv
// ============================================================================
// Module      : tb_axil_sram_dma_master
// Description : Directed + randomized bench with AXI-Lite SRAM slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_sram_dma_master;

    localparam int LEN_W = 10;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             done, err;
    logic [31:0]      s_data;
    logic             s_valid, s_ready;
    logic [31:0]      m_data;
    logic             m_valid, m_ready;
    logic [31:0]      awaddr, wdata, araddr, rdata;
    logic             awvalid, awready, wvalid, wready;
    logic [3:0]       wstrb;
    logic [1:0]       bresp, rresp;
    logic             bvalid, bready, arvalid, arready, rvalid, rready;

    always #5 aclk = ~aclk;

    axil_sram_dma_master #(.LEN_W(LEN_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .done(done), .err(err),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready), .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave-side and stream-side environment state
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] aw_q[$], w_q[$], got_q[$], src_q[$];
    logic [31:0] err_wr_mask, err_rd_mask;
    int          wr_idx, rd_idx, done_cnt;
    int          mready_mode, mready_cnt;
    bit          slave_stall;
    bit          have_aw, have_w, b_pend, r_pend, b_fire, r_fire;
    int          b_dly, r_dly;
    logic [31:0] aw_lat, w_lat, ar_lat;

    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = 0; rresp = 0; s_valid = 0; s_data = 0; m_ready = 0;
        have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
        b_dly = 0; r_dly = 0; mready_cnt = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                s_valid = 0; have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
                b_fire = 0; r_fire = 0;
                continue;
            end
            if (done) done_cnt++;
            if (b_fire) bvalid = 0;
            if (r_fire) rvalid = 0;
            if (b_pend) begin
                if (b_dly == 0) begin
                    bvalid = 1; bresp = err_wr_mask[wr_idx] ? 2'b10 : 2'b00;
                    wr_idx++; b_pend = 0;
                end else b_dly--;
            end
            if (r_pend) begin
                if (r_dly == 0) begin
                    rvalid = 1;
                    rdata  = slv_mem.exists(ar_lat) ? slv_mem[ar_lat] : 32'h0;
                    rresp  = err_rd_mask[rd_idx] ? 2'b10 : 2'b00;
                    rd_idx++; r_pend = 0;
                end else r_dly--;
            end
            awready = !slave_stall && awvalid && ($urandom_range(0, 2) != 0);
            wready  = !slave_stall && wvalid && ($urandom_range(0, 2) != 0);
            arready = !slave_stall;
            s_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
            s_data  = (src_q.size() > 0) ? src_q[0] : $urandom;
            if (mready_mode == 0) m_ready = 1;
            else if (mready_mode == 1) begin
                if (!m_valid) begin m_ready = 0; mready_cnt = 0; end
                else if (mready_cnt < 5) begin m_ready = 0; mready_cnt++; end
                else begin m_ready = 1; mready_cnt = 0; end
            end else m_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (arvalid) check("ar_gate", {31'd0, m_valid && !m_ready}, 32'd0);
            if (awvalid && awready) begin aw_q.push_back(awaddr); aw_lat = awaddr; have_aw = 1; end
            if (wvalid && wready) begin
                w_q.push_back(wdata); w_lat = wdata; have_w = 1;
                check("wstrb", {28'd0, wstrb}, 32'hF);
            end
            if (have_aw && have_w) begin
                slv_mem[aw_lat] = w_lat; have_aw = 0; have_w = 0;
                b_pend = 1; b_dly = $urandom_range(0, 2);
            end
            if (arvalid && arready) begin ar_lat = araddr; r_pend = 1; r_dly = $urandom_range(0, 2); end
            b_fire = bvalid && bready;
            r_fire = rvalid && rready;
            if (s_valid && s_ready) void'(src_q.pop_front());
            if (m_valid && m_ready) got_q.push_back(m_data);
        end
    end

    // Issue one command and compare its effects with the reference model
    task automatic do_cmd(input bit wr, input logic [31:0] addr, input int len,
                          input logic [31:0] data[$], input string tag);
        logic [31:0] base, a;
        bit          exp_err;
        int          t;
        base = {addr[31:2], 2'b00};
        exp_err = 0;
        for (int i = 0; i < len; i++)
            if (wr ? err_wr_mask[i] : err_rd_mask[i]) exp_err = 1;
        aw_q.delete(); w_q.delete(); got_q.delete();
        wr_idx = 0; rd_idx = 0; done_cnt = 0;
        if (wr) for (int i = 0; i < len; i++) begin
            src_q.push_back(data[i]);
            ref_mem[base + 32'(4 * i)] = data[i];
        end
        @(negedge aclk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = LEN_W'(len);
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge aclk); t++; end
        check({tag, "_accept_to"}, {31'd0, t < 50}, 32'd1);
        @(negedge aclk);
        cmd_valid = 0;
        check({tag, "_err_clr"}, {31'd0, err}, 32'd0);
        if (len == 0) begin
            check({tag, "_len0_done"}, {31'd0, done}, 32'd1);
            check({tag, "_len0_valids"}, {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        end
        t = 0;
        while (!done && t < 3000) begin @(negedge aclk); t++; end
        check({tag, "_done_to"}, {31'd0, t < 3000}, 32'd1);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        t = 0;
        while (!wr && got_q.size() < len && t < 200) begin @(negedge aclk); t++; end
        repeat (2) @(negedge aclk);
        check({tag, "_done_cnt"}, done_cnt, 32'd1);
        if (wr) begin
            check({tag, "_aw_cnt"}, aw_q.size(), len);
            check({tag, "_w_cnt"}, w_q.size(), len);
            for (int i = 0; i < len; i++) begin
                a = base + 32'(4 * i);
                check({tag, "_awaddr"}, (i < aw_q.size()) ? aw_q[i] : 32'hx, a);
                check({tag, "_wdata"}, (i < w_q.size()) ? w_q[i] : 32'hx, data[i]);
            end
        end else begin
            check({tag, "_rd_cnt"}, got_q.size(), len);
            for (int i = 0; i < len; i++) begin
                a = base + 32'(4 * i);
                check({tag, "_rdata"}, (i < got_q.size()) ? got_q[i] : 32'hx,
                      ref_mem.exists(a) ? ref_mem[a] : 32'h0);
            end
        end
    endtask

    initial begin
        logic [31:0] d[$];
        logic [31:0] ra;
        int          rl, t;
        aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        err_wr_mask = 0; err_rd_mask = 0; mready_mode = 0; slave_stall = 0;
        #1;
        check("rst_outs", {20'd0, cmd_ready, done, err, m_valid, awvalid, wvalid,
                           arvalid, s_ready, bready, rready, |wstrb, 1'b0}, 32'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1;
        repeat (2) @(negedge aclk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        do_cmd(1, 32'h100, 4, d, "t1_wr");
        mready_mode = 0;
        do_cmd(0, 32'h100, 4, d, "t2_rd");
        mready_mode = 1;
        do_cmd(0, 32'h100, 3, d, "t3_rd_stall");
        mready_mode = 0;

        err_wr_mask = 32'h2;
        d = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
        do_cmd(1, 32'h200, 3, d, "t4_wr_err");
        err_wr_mask = 0;
        err_rd_mask = 32'h4;
        do_cmd(0, 32'h200, 3, d, "t4_rd_err");
        err_rd_mask = 0;

        d.delete();
        do_cmd(1, 32'h300, 0, d, "t5_len0");
        d = '{32'hDEADBEEF, 32'hCAFEF00D};
        do_cmd(1, 32'hFFFFFFFE, 2, d, "t5_wrap");
        do_cmd(0, 32'hFFFFFFFC, 2, d, "t5_wrap_rd");

        for (int k = 0; k < 6; k++) begin
            ra = {21'd0, 9'($urandom_range(0, 500)), 2'($urandom)};
            rl = $urandom_range(1, 8);
            d.delete();
            for (int i = 0; i < rl; i++) d.push_back($urandom);
            err_wr_mask = (k == 2) ? 32'($urandom) : 32'h0;
            do_cmd(1, ra, rl, d, "rnd_wr");
            err_wr_mask = 0;
            mready_mode = 2;
            do_cmd(0, ra, rl, d, "rnd_rd");
            mready_mode = 0;
        end

        slave_stall = 1;
        d = '{32'h55555555};
        src_q.push_back(d[0]);
        @(negedge aclk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_len = LEN_W'(1);
        t = 0;
        while (!awvalid && t < 50) begin
            @(negedge aclk);
            if (!cmd_ready) cmd_valid = 0;
            t++;
        end
        check("t6_reach_waddr", {31'd0, awvalid}, 32'd1);
        cmd_valid = 0;
        #2 aresetn = 0;
        #1;
        check("t6_rst_outs", {27'd0, awvalid, wvalid, done, err, m_valid}, 32'd0);
        src_q.delete();
        @(negedge aclk);
        slave_stall = 0;
        aresetn = 1;
        repeat (2) @(negedge aclk);
        check("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        d = '{32'h01234567, 32'h89ABCDEF};
        do_cmd(1, 32'h40, 2, d, "t6_post_wr");
        do_cmd(0, 32'h40, 2, d, "t6_post_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
